// File: rtl/wb_master_if.sv
// Request/response port plus Wishbone classic bus signals of the wb_master initiator.
// master: the initiator's view; slave: the environment (request source + bus responder).
interface wb_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        stb_o;
  logic        cyc_o;
  logic        ack_i;

  modport master (
    input  req_valid, req_we, req_adr, req_dat, req_sel, dat_i, ack_i,
    output req_ready, rsp_valid, rsp_dat, rsp_err,
    output adr_o, dat_o, we_o, sel_o, stb_o, cyc_o
  );

  modport slave (
    output req_valid, req_we, req_adr, req_dat, req_sel, dat_i, ack_i,
    input  req_ready, rsp_valid, rsp_dat, rsp_err,
    input  adr_o, dat_o, we_o, sel_o, stb_o, cyc_o
  );
endinterface

// File: rtl/wb_master.sv
// Wishbone classic single-transaction initiator driven by a valid/ready request port.
// Optional bus timeout abort is built when WB_MASTER_TIMEOUT_EN is defined.
module wb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst_n,
  wb_master_if.master bus
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("wb_master: TIMEOUT must be in 1..255");
  end

  typedef enum logic {StIdle, StBus} state_e;

  state_e      r_state;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_stb;
  logic        r_cyc;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_dat;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;
  logic       r_rsp_err;
  logic       w_timeout;

  // r_cnt holds the number of completed BUS cycles without ack, so this is the last allowed one.
  assign w_timeout   = (r_cnt == TimeoutLast);
  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_stb       <= 1'b0;
      r_cyc       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.req_valid) begin
            r_adr   <= bus.req_adr;
            r_dat   <= bus.req_dat;
            r_we    <= bus.req_we;
            r_sel   <= bus.req_sel;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= StBus;
`ifdef WB_MASTER_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        StBus: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (bus.ack_i) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_state     <= StIdle;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= r_we ? '0 : bus.dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_state     <= StIdle;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + 8'd1;
`endif
          end
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == StIdle);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_dat   = r_rsp_dat;
  assign bus.adr_o     = r_adr;
  assign bus.dat_o     = r_dat;
  assign bus.we_o      = r_we;
  assign bus.sel_o     = r_sel;
  assign bus.stb_o     = r_stb;
  assign bus.cyc_o     = r_cyc;

endmodule

// File: doc/wb_master.md
Name: wb_master

Overview:
- Wishbone classic single-cycle bus initiator: turns a simple valid/ready request port into one Wishbone read or write, then returns a one-cycle response.
- Drives the same bus that the GPIO and other peripheral responders in the design sit on.
- Intended front end for a debug/command source (UART bridge, test sequencer) that needs bus access to the peripherals.
- One transaction outstanding at a time; no bursts, no pipelining.

Parameters:
- TIMEOUT, 16, number of bus cycles to wait for ack_i before aborting. Legal range 1..255; an 8-bit counter is used. Only used with the optional feature.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request; equals (state==IDLE)
- req_we  input  1  1=write, 0=read
- req_adr  input  32  byte address
- req_dat  input  32  write data
- req_sel  input  4  byte selects
- rsp_valid  output  1  one-cycle pulse: transaction finished
- rsp_dat  output  32  read data; 0 for writes and aborts
- rsp_err  output  1  transaction aborted by timeout; qualified by rsp_valid
- adr_o  output  32  Wishbone ADR_O
- dat_o  output  32  Wishbone DAT_O
- dat_i  input  32  Wishbone DAT_I
- we_o  output  1  Wishbone WE_O
- sel_o  output  4  Wishbone SEL_O
- stb_o  output  1  Wishbone STB_O
- cyc_o  output  1  Wishbone CYC_O
- ack_i  input  1  Wishbone ACK_I

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. All state registers reset immediately when rst_n falls.
- Reset values:
  - adr_o, dat_o, rsp_dat = 0; sel_o = 0.
  - we_o, stb_o, cyc_o, rsp_valid, rsp_err = 0.
  - State = IDLE, so req_ready = 1. Requests are ignored while rst_n is low.
- States: IDLE and BUS. All outputs except req_ready are registered.
- IDLE:
  - On req_valid & req_ready, latch req_adr, req_dat, req_we and req_sel into adr_o, dat_o, we_o and sel_o.
  - Set cyc_o = stb_o = 1 on the same edge and go to BUS.
  - ack_i is ignored in IDLE.
- BUS:
  - cyc_o, stb_o and all address/data outputs stay stable until termination.
  - ack_i is accepted in any BUS cycle, including the first.
  - On the edge where ack_i=1:
    - cyc_o = stb_o = 0 and state goes to IDLE.
    - rsp_valid = 1 for exactly one cycle.
    - rsp_dat = dat_i for a read, 0 for a write; rsp_err = 0.
- Responses:
  - rsp_valid deasserts on the following edge. rsp_dat holds its value until the next response.
  - The response has no backpressure; the consumer must take it in the cycle it is valid.
- Back-to-back requests:
  - A new request can be accepted in the same cycle rsp_valid is high.
  - Between two transactions stb_o is therefore low for at least one cycle. This guarantees that a registered-ack responder drops its ack.
- Latency: with ack returned k cycles after stb_o rises (k ≥ 0), rsp_valid rises k+1 cycles after stb_o rises.
- Reset mid-transaction: cyc_o and stb_o drop asynchronously and no rsp_valid is produced.
- we_o/adr_o hold: after a transaction ends, we_o, adr_o, dat_o and sel_o keep their last values, which is harmless because cyc_o=0.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUS and increments each BUS cycle without ack_i.
  - If cyc_o has been high for TIMEOUT cycles with no ack_i, the block aborts on the edge closing cycle TIMEOUT: cyc_o = stb_o = 0, state = IDLE, rsp_valid = 1 for one cycle, rsp_err = 1, rsp_dat = 0.
  - If ack_i arrives in the same cycle the timeout would fire, ack wins: normal completion with rsp_err = 0.
- Undefined:
  - No counter is built and rsp_err is tied 0.
  - The block waits in BUS indefinitely for ack_i.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs at their reset values, req_ready=1. Pulse rst_n low while cyc_o=1 -> cyc_o/stb_o go 0 before the next clock edge; no rsp_valid follows.
- Write: req adr=0x0000_0002, dat=0x0000_0001, we=1, sel=0xF; responder acks 1 cycle after stb_o rises -> adr_o/dat_o/we_o stable while stb_o=1; stb_o high for 2 cycles; rsp_valid one cycle, rsp_dat=0, rsp_err=0.
- Read with wait states: req adr=0x0000_0001, we=0; ack 3 cycles after stb_o with dat_i=0x0000_0001 -> rsp_valid exactly 4 cycles after stb_o rose, rsp_dat=0x0000_0001.
- Back-to-back: req_valid held high for a write then a read, responder acks in the first cycle -> second request accepted in the rsp_valid cycle; exactly 1 cycle with stb_o=0 between transactions; ack_i pulses in IDLE cause no response.
- Timeout with WB_MASTER_TIMEOUT_EN and TIMEOUT=4: no ack -> stb_o high exactly 4 cycles, then rsp_valid=1, rsp_err=1, rsp_dat=0, req_ready=1. With ack in cycle 4 -> normal response, rsp_err=0.
- Macro off: no ack for 100 cycles -> stb_o stays 1, rsp_valid stays 0, req_ready=0. Ack at cycle 100 -> normal completion.
